// File: rtl/mlp_sequencer.sv
// mlp_sequencer: control sequencer for a three-layer MLP datapath.
//
// One inference runs CLEAR (accumulator clear), RUN (layer-1 row reads and
// the layer-2 column reads that trail them by PIPE_LAT cycles), L3
// (output-layer enable for L3_CYCLES cycles) and DONE (one-cycle pulse).
// Every output is a flop. The value a state decides at a rising edge is
// visible during the following cycle, so each output trails the state and
// inputs that produced it by one cycle.
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-low
//   start         begin one inference (sampled only in IDLE)
//   abort         cancel any inference; forces IDLE, all strobes low
//   mem_ready     weight memories can deliver; low stalls RUN
//   busy          state was not IDLE
//   done          one-cycle completion pulse
//   acc_clear     one-cycle accumulator clear pulse
//   w1_rd_en      layer-1 row read strobe, w1_row_addr row index
//   w2_rd_en      layer-2 column read strobe, w2_col_addr column index
//   enableLayer3  output-layer enable
//   stall_count   stalled RUN cycles, saturating at 16'hFFFF
//
// Build option: define SEQ_PERF_CNT_EN to include the stall counter.
// Without it stall_count is tied to zero.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one cycle: clear accumulators, zero cycle counter c
// RUN   | stream rows/columns, c advances when mem_ready=1
// L3    | enableLayer3 high, down-counter runs L3_CYCLES cycles
// DONE  | one-cycle done pulse, back to IDLE

module mlp_sequencer #(
  parameter int N_HIDDEN  = 200,
  parameter int PIPE_LAT  = 11,
  parameter int L3_CYCLES = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        acc_clear,
  output logic        w1_rd_en,
  output logic [7:0]  w1_row_addr,
  output logic        w2_rd_en,
  output logic [7:0]  w2_col_addr,
  output logic        enableLayer3,
  output logic [15:0] stall_count
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, L3, DONE} state_t;

  localparam int L3W = (L3_CYCLES > 1) ? $clog2(L3_CYCLES) : 1;
  localparam logic [8:0]     C_N    = 9'(N_HIDDEN);
  localparam logic [8:0]     C_P    = 9'(PIPE_LAT);
  localparam logic [8:0]     C_LAST = 9'(N_HIDDEN + PIPE_LAT - 1);
  localparam logic [L3W-1:0] L3_LOAD = L3W'(L3_CYCLES - 1);

  state_t         state_q, state_d;
  logic [8:0]     c_q, c_d;
  logic [L3W-1:0] l3_q, l3_d;

  logic busy_q, busy_d, done_q, done_d, acc_clear_q, acc_clear_d;
  logic w1_rd_en_q, w1_rd_en_d, w2_rd_en_q, w2_rd_en_d, en3_q, en3_d;
  logic [7:0] w1_row_addr_q, w1_row_addr_d, w2_col_addr_q, w2_col_addr_d;

  always_comb begin
    state_d       = state_q;
    c_d           = c_q;
    l3_d          = l3_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    acc_clear_d   = 1'b0;
    w1_rd_en_d    = 1'b0;
    w1_row_addr_d = 8'd0;
    w2_rd_en_d    = 1'b0;
    w2_col_addr_d = 8'd0;
    en3_d         = 1'b0;
    if (abort) begin
      state_d = IDLE;
      c_d     = 9'd0;
      l3_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = CLEAR;
        end
        CLEAR: begin
          busy_d      = 1'b1;
          acc_clear_d = 1'b1;
          c_d         = 9'd0;
          state_d     = RUN;
        end
        RUN: begin
          busy_d = 1'b1;
          // Addresses track c even while stalled, so they hold across a stall.
          if (c_q < C_N)  w1_row_addr_d = c_q[7:0];
          if (c_q >= C_P) w2_col_addr_d = 8'(c_q - C_P);
          if (mem_ready) begin
            w1_rd_en_d = (c_q < C_N);
            w2_rd_en_d = (c_q >= C_P);
            if (c_q == C_LAST) begin
              state_d = L3;
              l3_d    = L3_LOAD;
            end else begin
              c_d = c_q + 9'd1;
            end
          end
        end
        L3: begin
          busy_d = 1'b1;
          en3_d  = 1'b1;
          if (l3_q == '0) state_d = DONE;
          else            l3_d    = l3_q - 1'b1;
        end
        DONE: begin
          busy_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      c_q           <= 9'd0;
      l3_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      acc_clear_q   <= 1'b0;
      w1_rd_en_q    <= 1'b0;
      w1_row_addr_q <= 8'd0;
      w2_rd_en_q    <= 1'b0;
      w2_col_addr_q <= 8'd0;
      en3_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      c_q           <= c_d;
      l3_q          <= l3_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      acc_clear_q   <= acc_clear_d;
      w1_rd_en_q    <= w1_rd_en_d;
      w1_row_addr_q <= w1_row_addr_d;
      w2_rd_en_q    <= w2_rd_en_d;
      w2_col_addr_q <= w2_col_addr_d;
      en3_q         <= en3_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign acc_clear    = acc_clear_q;
  assign w1_rd_en     = w1_rd_en_q;
  assign w1_row_addr  = w1_row_addr_q;
  assign w2_rd_en     = w2_rd_en_q;
  assign w2_col_addr  = w2_col_addr_q;
  assign enableLayer3 = en3_q;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (!abort) begin
      if (state_q == CLEAR)
        stall_count_d = 16'd0;
      else if (state_q == RUN && !mem_ready && stall_count_q != 16'hFFFF)
        stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_count_q <= 16'd0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_mlp_sequencer.sv
module tb_mlp_sequencer;

  localparam int NH  = 200;
  localparam int PL  = 11;
  localparam int L3C = 50;
  localparam int RUN_LEN = NH + PL;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, abort = 1'b0, mem_ready = 1'b0;
  logic busy, done, acc_clear, w1_rd_en, w2_rd_en, enableLayer3;
  logic [7:0] w1_row_addr, w2_col_addr;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  mlp_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mem_ready(mem_ready),
    .busy(busy), .done(done), .acc_clear(acc_clear),
    .w1_rd_en(w1_rd_en), .w1_row_addr(w1_row_addr),
    .w2_rd_en(w2_rd_en), .w2_col_addr(w2_col_addr),
    .enableLayer3(enableLayer3), .stall_count(stall_count)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        acc_clear;
    logic        w1_en;
    logic [7:0]  w1_addr;
    logic        w2_en;
    logic [7:0]  w2_addr;
    logic        en3;
    logic [15:0] stall;
  } outs_t;

  typedef struct packed {
    logic  rs, st, ab, mr;
    outs_t e;
  } vec_t;

  outs_t act;
  always_comb act = {busy, done, acc_clear, w1_rd_en, w1_row_addr,
                     w2_rd_en, w2_col_addr, enableLayer3, stall_count};

  int nvec = 0;
  int nfail = 0;
  int model_stall = 0;

  outs_t exp_a [0:1023];
  logic  st_a [0:1023];
  logic  ab_a [0:1023];
  logic  mr_a [0:1023];
  logic  rs_a [0:1023];

  function automatic logic [15:0] pstall();
    return PERF ? 16'(model_stall) : 16'd0;
  endfunction

  function automatic outs_t mk(logic b, logic d, logic ac, logic w1e, int w1a,
                               logic w2e, int w2a, logic e3, logic [15:0] s);
    outs_t o;
    o.busy = b; o.done = d; o.acc_clear = ac;
    o.w1_en = w1e; o.w1_addr = 8'(w1a);
    o.w2_en = w2e; o.w2_addr = 8'(w2a);
    o.en3 = e3; o.stall = s;
    return o;
  endfunction

  task automatic apply(input logic rs, input logic st, input logic ab, input logic mr,
                       input outs_t e, input string nm, input int k);
    @(negedge clk);
    reset = rs; start = st; abort = ab; mem_ready = mr;
    @(posedge clk);
    #1;
    nvec++;
    if (act !== e) begin
      nfail++;
      $display("FAIL %s edge=%0d got=%h want=%h", nm, k, act, e);
    end
  endtask

  // Builds the expected per-edge outputs of one inference from the
  // sequencing rules (run length, address offsets, L3 length), then drives it.
  // Edge 0 samples start in IDLE. abort_u: abort on the RUN edge whose cycle
  // index equals abort_u (-1 none). rst_k: reset on that edge (-1 none).
  task automatic run_scenario(input int mode, input int abort_u, input int rst_k,
                              input bit hold, input string nm);
    int k, u, s5;
    bit killed;
    outs_t e;
    k = 0; u = 0; s5 = 0; killed = 1'b0;
    st_a[0] = 1'b1; ab_a[0] = 1'b0; mr_a[0] = 1'b1; rs_a[0] = 1'b1;
    exp_a[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, pstall());
    model_stall = 0;
    st_a[1] = hold; ab_a[1] = 1'b0; mr_a[1] = 1'b1; rs_a[1] = 1'b1;
    exp_a[1] = mk(1, 0, 1, 0, 0, 0, 0, 0, 16'd0);
    k = 2;
    while (u < RUN_LEN && k < 1000) begin
      st_a[k] = hold; rs_a[k] = 1'b1; ab_a[k] = (u == abort_u);
      case (mode)
        1:       begin mr_a[k] = !(u == 100 && s5 < 5); if (!mr_a[k]) s5++; end
        2:       mr_a[k] = ($urandom_range(0, 3) != 0);
        default: mr_a[k] = 1'b1;
      endcase
      if (ab_a[k]) begin
        exp_a[k] = mk(0, 0, 0, 0, 0, 0, 0, 0, pstall());
        killed = 1'b1;
        k++;
        break;
      end
      e = mk(1, 0, 0, 0, (u < NH) ? u : 0, 0, (u >= PL) ? u - PL : 0, 0, 16'd0);
      if (mr_a[k]) begin
        e.w1_en = (u < NH);
        e.w2_en = (u >= PL);
        u++;
      end else if (model_stall < 65535) begin
        model_stall++;
      end
      e.stall = pstall();
      exp_a[k] = e;
      k++;
    end
    if (!killed) begin
      for (int j = 0; j < L3C; j++) begin
        st_a[k] = hold; mr_a[k] = logic'($urandom_range(0, 1));
        if (k == rst_k) begin
          rs_a[k] = 1'b0; ab_a[k] = 1'b1; st_a[k] = 1'b1;
          model_stall = 0;
          exp_a[k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 16'd0);
          killed = 1'b1;
          k++;
          break;
        end
        rs_a[k] = 1'b1; ab_a[k] = 1'b0;
        exp_a[k] = mk(1, 0, 0, 0, 0, 0, 0, 1, pstall());
        k++;
      end
    end
    if (!killed) begin
      st_a[k] = hold; ab_a[k] = 1'b0; mr_a[k] = 1'b1; rs_a[k] = 1'b1;
      exp_a[k] = mk(1, 1, 0, 0, 0, 0, 0, 0, pstall());
      k++;
    end
    if (killed || !hold) begin
      st_a[k] = 1'b0; ab_a[k] = 1'b0; mr_a[k] = 1'b1; rs_a[k] = 1'b1;
      exp_a[k] = mk(0, 0, 0, 0, 0, 0, 0, 0, pstall());
      k++;
    end
    for (int i = 0; i < k; i++)
      apply(rs_a[i], st_a[i], ab_a[i], mr_a[i], exp_a[i], nm, i);
  endtask

  vec_t tbl [0:9];

  initial begin
    //            rs st ab mr  busy done acc w1e w1a w2e w2a e3 stall
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 16'd0)};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 16'd0)};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 16'd0)};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 16'd0)};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 0, 16'd0)};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 1, 0, 0, 0, 0, 16'd0)};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 1, 0, 0, 0, PERF ? 16'd1 : 16'd0)};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 1, 0, 0, 0, PERF ? 16'd1 : 16'd0)};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, PERF ? 16'd1 : 16'd0)};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, PERF ? 16'd1 : 16'd0)};

    apply(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 16'd0), "reset", 0);
    for (int i = 0; i < 10; i++)
      apply(tbl[i].rs, tbl[i].st, tbl[i].ab, tbl[i].mr, tbl[i].e, "table", i);
    model_stall = 1;

    run_scenario(0, -1, -1, 1'b0, "full_run");
    run_scenario(1, -1, -1, 1'b0, "stall5_at_100");
    for (int r = 0; r < 3; r++)
      run_scenario(2, -1, -1, 1'b0, "random_ready");
    run_scenario(0, 150, -1, 1'b0, "abort_at_150");
    run_scenario(0, -1, -1, 1'b0, "after_abort");
    run_scenario(2, -1, -1, 1'b1, "start_held_1");
    run_scenario(0, -1, -1, 1'b1, "start_held_2");
    run_scenario(0, -1, -1, 1'b0, "start_held_3");
    run_scenario(0, -1, 2 + RUN_LEN + 20, 1'b0, "reset_in_l3");
    run_scenario(1, -1, -1, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
